mem_arbiter: RTL and testbench

Single-port RAM arbiter and response block serving the datapath's instruction fetch and the EX/MEM data request. Accepts level-held requests (iREN; dREN/dWEN), grants one at a time with data priority, and drives the RAM port. Registers the returned word and returns it with a one-cycle hit pulse (ihit or dhit). The requester drops its request on the edge where it samples the hit. Sits between the pipeline latches and the RAM model, in place of a direct RAM connection.

---
 rtl/mem_arbiter_if.sv | 31 +++
 rtl/mem_arbiter.sv | 94 +++++++++
 tb/tb_mem_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request, response and RAM-port signals between the pipeline, the RAM model and mem_arbiter.
// The master modport is the arbiter's view; slave is the pipeline-plus-RAM side.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        ihit;
    logic [31:0] imemload;
    logic        dhit;
    logic [31:0] dmemload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        timeout_err;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ihit, imemload, dhit, dmemload, ramREN, ramWEN, ramaddr, ramstore, timeout_err
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ihit, imemload, dhit, dmemload, ramREN, ramWEN, ramaddr, ramstore, timeout_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data beats fetch, one access at a time, registered load word plus one-cycle hit.
// Latency: strobe the cycle after the request is sampled, hit the cycle after ACCESS; a stalled RAM aborts after TIMEOUT cycles.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, DWAIT, IWAIT, DRESP, IRESP} state_t;

    // ramstate encoding follows cpu_types_pkg: FREE, BUSY, ACCESS, ERROR
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            bus.ihit        <= 1'b0;
            bus.dhit        <= 1'b0;
            bus.ramREN      <= 1'b0;
            bus.ramWEN      <= 1'b0;
            bus.ramaddr     <= '0;
            bus.ramstore    <= '0;
            bus.imemload    <= '0;
            bus.dmemload    <= '0;
            bus.timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (bus.dREN || bus.dWEN) begin
                        bus.ramaddr  <= bus.daddr;
                        bus.ramstore <= bus.dstore;
                        bus.ramWEN   <= bus.dWEN;
                        bus.ramREN   <= !bus.dWEN;
                        state        <= DWAIT;
                    end else if (bus.iREN) begin
                        bus.ramaddr <= bus.iaddr;
                        bus.ramREN  <= 1'b1;
                        state       <= IWAIT;
                    end
                end
                DWAIT, IWAIT: begin
                    // ACCESS takes precedence over an expiring counter on the same edge
                    if (bus.ramstate == RAM_ACCESS) begin
                        bus.ramREN <= 1'b0;
                        bus.ramWEN <= 1'b0;
                        if (state == DWAIT) begin
                            // ramWEN still holds the latched op here; writes keep the old load word
                            if (!bus.ramWEN) begin
                                bus.dmemload <= bus.ramload;
                            end
                            bus.dhit <= 1'b1;
                            state    <= DRESP;
                        end else begin
                            bus.imemload <= bus.ramload;
                            bus.ihit     <= 1'b1;
                            state        <= IRESP;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        bus.ramREN      <= 1'b0;
                        bus.ramWEN      <= 1'b0;
                        bus.timeout_err <= 1'b1;
                        if (state == DWAIT) begin
                            bus.dmemload <= ERRWORD;
                            bus.dhit     <= 1'b1;
                            state        <= DRESP;
                        end else begin
                            bus.imemload <= ERRWORD;
                            bus.ihit     <= 1'b1;
                            state        <= IRESP;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DRESP, IRESP: begin
                    bus.ihit <= 1'b0;
                    bus.dhit <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with TIMEOUT=4: reads, write/fetch collision, latching, timeout, ERROR retry, reset.
module tb_mem_arbiter;
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(4), .ERRWORD(32'hBAD1BAD1)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.master)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int ren_cycles = 0;
    int dhit_cnt = 0;
    int ihit_cnt = 0;
    int dual_hit = 0;

    always @(negedge CLK) begin
        if (bus.ramREN) ren_cycles++;
        if (bus.dhit) dhit_cnt++;
        if (bus.ihit) ihit_cnt++;
        if (bus.ihit && bus.dhit) dual_hit++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    int base;

    initial begin
        bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = FREE;

        // reset state
        #2;
        check("rst_ramREN", 32'(bus.ramREN), 0);
        check("rst_ramWEN", 32'(bus.ramWEN), 0);
        check("rst_hits", 32'({bus.ihit, bus.dhit}), 0);
        check("rst_ramaddr", bus.ramaddr, 0);
        check("rst_loads", bus.imemload | bus.dmemload, 0);
        check("rst_terr", 32'(bus.timeout_err), 0);
        #11 nRST = 1;
        tick();

        // data read with two BUSY cycles
        base = ren_cycles;
        bus.dREN = 1; bus.daddr = 32'h100; bus.ramstate = BUSY;
        tick();
        check("rd_ren1", 32'(bus.ramREN), 1);
        check("rd_addr", bus.ramaddr, 32'h100);
        check("rd_nohit", 32'(bus.dhit), 0);
        tick();
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
        tick();
        check("rd_dhit", 32'(bus.dhit), 1);
        check("rd_ihit", 32'(bus.ihit), 0);
        check("rd_load", bus.dmemload, 32'hDEADBEEF);
        check("rd_strobe_off", 32'(bus.ramREN), 0);
        check("rd_ren_cycles", 32'(ren_cycles - base), 3);
        bus.dREN = 0; bus.ramstate = FREE;
        tick();
        check("rd_hit_once", 32'(bus.dhit), 0);

        // collision: write wins, one IDLE cycle, then fetch
        bus.iREN = 1; bus.iaddr = 32'h0;
        bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'h12345678;
        bus.ramstate = ACCESS; bus.ramload = 32'h77777777;
        tick();
        check("col_wen", 32'(bus.ramWEN), 1);
        check("col_ren", 32'(bus.ramREN), 0);
        check("col_addr", bus.ramaddr, 32'h200);
        check("col_store", bus.ramstore, 32'h12345678);
        tick();
        check("col_dhit", 32'(bus.dhit), 1);
        check("col_wr_keeps_load", bus.dmemload, 32'hDEADBEEF);
        bus.dWEN = 0;
        tick();
        check("col_idle_strobes", 32'({bus.ramREN, bus.ramWEN}), 0);
        check("col_idle_hits", 32'({bus.ihit, bus.dhit}), 0);
        bus.ramload = 32'h11223344;
        tick();
        check("col_fetch_ren", 32'(bus.ramREN), 1);
        check("col_fetch_addr", bus.ramaddr, 32'h0);
        tick();
        check("col_ihit", 32'(bus.ihit), 1);
        check("col_dhit_low", 32'(bus.dhit), 0);
        check("col_iload", bus.imemload, 32'h11223344);
        bus.iREN = 0; bus.ramstate = FREE;
        tick();

        // inputs changed and request withdrawn during DWAIT
        base = dhit_cnt;
        bus.dREN = 1; bus.daddr = 32'h100; bus.ramstate = BUSY;
        tick();
        bus.daddr = 32'h300; bus.dREN = 0;
        tick();
        check("lat_addr", bus.ramaddr, 32'h100);
        check("lat_ren", 32'(bus.ramREN), 1);
        bus.ramstate = ACCESS; bus.ramload = 32'h55AA55AA;
        tick();
        check("lat_dhit", 32'(bus.dhit), 1);
        check("lat_load", bus.dmemload, 32'h55AA55AA);
        bus.ramstate = FREE;
        tick();
        tick();
        check("lat_no_new_req", 32'({bus.ramREN, bus.ramWEN}), 0);
        check("lat_dhit_count", 32'(dhit_cnt - base), 1);

        // ERROR retried three times, then ACCESS
        bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = ERROR;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("err_ren_held", 32'(bus.ramREN), 1);
            tick();
        end
        check("err_ren_last", 32'(bus.ramREN), 1);
        bus.ramstate = ACCESS; bus.ramload = 32'hCAFEF00D;
        tick();
        check("err_ihit", 32'(bus.ihit), 1);
        check("err_iload", bus.imemload, 32'hCAFEF00D);
        check("err_terr", 32'(bus.timeout_err), 0);
        bus.iREN = 0; bus.ramstate = FREE;
        tick();

        // timeout with RAM stuck BUSY
        base = ren_cycles;
        bus.dREN = 1; bus.daddr = 32'h80; bus.ramstate = BUSY;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("to_ren_held", 32'(bus.ramREN), 1);
            tick();
        end
        check("to_dhit", 32'(bus.dhit), 1);
        check("to_ren_off", 32'(bus.ramREN), 0);
        check("to_errword", bus.dmemload, 32'hBAD1BAD1);
        check("to_terr", 32'(bus.timeout_err), 1);
        check("to_ren_cycles", 32'(ren_cycles - base), 4);
        bus.dREN = 0;
        tick();
        bus.dWEN = 1; bus.daddr = 32'h84; bus.dstore = 32'h1; bus.ramstate = ACCESS;
        tick();
        tick();
        check("to_after_dhit", 32'(bus.dhit), 1);
        check("to_sticky", 32'(bus.timeout_err), 1);
        bus.dWEN = 0; bus.ramstate = FREE;
        tick();

        // reset in the middle of IWAIT
        bus.iREN = 1; bus.iaddr = 32'h44; bus.ramstate = BUSY;
        tick();
        check("rw_ren", 32'(bus.ramREN), 1);
        #2 nRST = 0;
        #1;
        check("rw_async_ren", 32'(bus.ramREN), 0);
        check("rw_async_addr", bus.ramaddr, 0);
        check("rw_async_terr", 32'(bus.timeout_err), 0);
        check("rw_async_loads", bus.imemload | bus.dmemload, 0);
        bus.iREN = 0; bus.ramstate = ACCESS;
        tick();
        #3 nRST = 1;
        base = ihit_cnt;
        tick();
        tick();
        tick();
        check("rw_no_ihit", 32'(ihit_cnt - base), 0);
        bus.iREN = 1; bus.iaddr = 32'h48; bus.ramload = 32'h0BADCAFE;
        tick();
        check("rw_fresh_ren", 32'(bus.ramREN), 1);
        check("rw_fresh_addr", bus.ramaddr, 32'h48);
        tick();
        check("rw_fresh_ihit", 32'(bus.ihit), 1);
        check("rw_fresh_iload", bus.imemload, 32'h0BADCAFE);
        bus.iREN = 0; bus.ramstate = FREE;
        tick();

        check("never_dual_hit", 32'(dual_hit), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
